// File: rtl/relu_maxpool2x2.sv
// rtl/relu_maxpool2x2.sv - optional ReLU, border crop and 2x2 stride-2 fp32 max pooling
// Two-stage pipeline: stage 1 pairs columns and reads the half-row buffer, stage 2 pairs rows.
module relu_maxpool2x2 #(
    parameter int C_WIDTH  = 9,
    parameter int C_HEIGHT = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                param_ena,
    input  logic [C_WIDTH-1:0]  param_width_in,
    input  logic [C_WIDTH-1:0]  param_width_out,
    input  logic [C_HEIGHT-1:0] param_height_in,
    input  logic                param_relu,
    input  logic                pxl_ena_in,
    input  logic [31:0]         pxl_in,
    output logic                pxl_ena_out,
    output logic [31:0]         pxl_out,
    output logic                frame_done
);

    localparam int LB_DEPTH = 2 ** (C_WIDTH - 1);

    // Order-preserving key: unsigned compare of keys matches fp ordering.
    function automatic logic [31:0] fp_key(input logic [31:0] x);
        return x[31] ? ~x : (x | 32'h8000_0000);
    endfunction

    // Ties keep the first (earlier) operand.
    function automatic logic [31:0] fp_max(input logic [31:0] a, input logic [31:0] b);
        return (fp_key(b) > fp_key(a)) ? b : a;
    endfunction

    logic [C_WIDTH-1:0]  width_in_q, width_in_d;
    logic [C_WIDTH-1:0]  width_out_q, width_out_d;
    logic [C_HEIGHT-1:0] height_in_q, height_in_d;
    logic                relu_q, relu_d;
    logic [C_WIDTH-1:0]  col_q, col_d;
    logic [C_HEIGHT-1:0] row_q, row_d;
    logic [31:0]         hold_q, hold_d;
    logic                s1_valid_q, s1_valid_d;
    logic [31:0]         s1_h_q, s1_h_d;
    logic [31:0]         s1_lb_q, s1_lb_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_q, out_d;
    logic                frame_done_q, frame_done_d;

    logic [31:0]         lb_q [0:LB_DEPTH-1];
    logic [C_WIDTH-2:0]  lb_addr;
    logic                lb_we;

    logic                active;
    logic                accept;
    logic                col_last;
    logic                row_last;
    logic                keep;
    logic [31:0]         x;
    logic [31:0]         h;

    always_comb begin
        active   = (width_in_q != '0) && (height_in_q != '0);
        accept   = pxl_ena_in && active && !param_ena;
        x        = (relu_q && pxl_in[31]) ? 32'h0000_0000 : pxl_in;
        col_last = (col_q == width_in_q - C_WIDTH'(1));
        row_last = (row_q == height_in_q - C_HEIGHT'(1));
        keep     = (col_q < (width_out_q & ~C_WIDTH'(1))) &&
                   (row_q < (height_in_q & ~C_HEIGHT'(1)));
        h        = fp_max(hold_q, x);
        lb_addr  = col_q[C_WIDTH-1:1];
    end

    always_comb begin
        width_in_d   = width_in_q;
        width_out_d  = width_out_q;
        height_in_d  = height_in_q;
        relu_d       = relu_q;
        col_d        = col_q;
        row_d        = row_q;
        hold_d       = hold_q;
        s1_valid_d   = 1'b0;
        s1_h_d       = s1_h_q;
        s1_lb_d      = s1_lb_q;
        out_valid_d  = 1'b0;
        out_d        = out_q;
        frame_done_d = 1'b0;
        lb_we        = 1'b0;

        if (param_ena) begin
            width_in_d  = param_width_in;
            width_out_d = param_width_out;
            height_in_d = param_height_in;
            relu_d      = param_relu;
            col_d       = '0;
            row_d       = '0;
            hold_d      = '0;
        end else begin
            if (s1_valid_q) begin
                out_valid_d = 1'b1;
                out_d       = fp_max(s1_lb_q, s1_h_q);
            end
            if (accept) begin
                if (col_last) begin
                    col_d = '0;
                    if (row_last) begin
                        row_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        row_d = row_q + C_HEIGHT'(1);
                    end
                end else begin
                    col_d = col_q + C_WIDTH'(1);
                end

                if (keep) begin
                    if (!col_q[0]) begin
                        hold_d = x;
                    end else if (!row_q[0]) begin
                        lb_we = 1'b1;
                    end else begin
                        s1_valid_d = 1'b1;
                        s1_h_d     = h;
                        s1_lb_d    = lb_q[lb_addr];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            width_in_q   <= '0;
            width_out_q  <= '0;
            height_in_q  <= '0;
            relu_q       <= 1'b0;
            col_q        <= '0;
            row_q        <= '0;
            hold_q       <= '0;
            s1_valid_q   <= 1'b0;
            s1_h_q       <= '0;
            s1_lb_q      <= '0;
            out_valid_q  <= 1'b0;
            out_q        <= '0;
            frame_done_q <= 1'b0;
        end else begin
            width_in_q   <= width_in_d;
            width_out_q  <= width_out_d;
            height_in_q  <= height_in_d;
            relu_q       <= relu_d;
            col_q        <= col_d;
            row_q        <= row_d;
            hold_q       <= hold_d;
            s1_valid_q   <= s1_valid_d;
            s1_h_q       <= s1_h_d;
            s1_lb_q      <= s1_lb_d;
            out_valid_q  <= out_valid_d;
            out_q        <= out_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (lb_we) begin
            lb_q[lb_addr] <= h;
        end
    end

    assign pxl_ena_out = out_valid_q;
    assign pxl_out     = out_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// tb/tb_relu_maxpool2x2.sv - directed bench for relu_maxpool2x2
module tb_relu_maxpool2x2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        param_ena = 1'b0;
    logic [8:0]  param_width_in = '0;
    logic [8:0]  param_width_out = '0;
    logic [8:0]  param_height_in = '0;
    logic        param_relu = 1'b0;
    logic        pxl_ena_in = 1'b0;
    logic [31:0] pxl_in = '0;
    logic        pxl_ena_out;
    logic [31:0] pxl_out;
    logic        frame_done;

    relu_maxpool2x2 #(.C_WIDTH(9), .C_HEIGHT(9)) dut (
        .clk             (clk),
        .rst             (rst),
        .param_ena       (param_ena),
        .param_width_in  (param_width_in),
        .param_width_out (param_width_out),
        .param_height_in (param_height_in),
        .param_relu      (param_relu),
        .pxl_ena_in      (pxl_ena_in),
        .pxl_in          (pxl_in),
        .pxl_ena_out     (pxl_ena_out),
        .pxl_out         (pxl_out),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    logic [31:0] exp_val [$];
    int          exp_cyc [$];
    int          fd_cyc  [$];
    logic [31:0] vin  [0:35];
    logic [31:0] vexp [0:3];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Small non-negative/negative integer to fp32 bits.
    function automatic logic [31:0] fp(input int v);
        int m;
        int e;
        logic [31:0] mant;
        m = (v < 0) ? -v : v;
        if (m == 0) return 32'h0000_0000;
        e = 0;
        for (int i = 0; i < 24; i++) if ((m >> i) != 0) e = i;
        mant = (32'(m) << (23 - e)) & 32'h007F_FFFF;
        return {v < 0, 8'(127 + e), mant[22:0]};
    endfunction

    always @(negedge clk) begin
        if (pxl_ena_out) begin
            if (exp_val.size() == 0) begin
                check_eq("spurious_out", {31'b0, pxl_ena_out}, 32'h0);
            end else begin
                check_eq("pool_val", pxl_out, exp_val.pop_front());
                check_eq("pool_lat", 32'(cyc), 32'(exp_cyc.pop_front()));
            end
        end
        if (frame_done) begin
            if (fd_cyc.size() == 0) begin
                check_eq("spurious_done", {31'b0, frame_done}, 32'h0);
            end else begin
                check_eq("done_lat", 32'(cyc), 32'(fd_cyc.pop_front()));
            end
        end
    end

    task automatic idle_cycle();
        @(posedge clk); #1;
        pxl_ena_in = 1'b0;
        pxl_in     = $urandom;
    endtask

    task automatic load(input int win, input int wout, input int h, input bit relu);
        @(posedge clk); #1;
        param_ena       = 1'b1;
        param_width_in  = 9'(win);
        param_width_out = 9'(wout);
        param_height_in = 9'(h);
        param_relu      = relu;
        pxl_ena_in      = 1'b1;
        pxl_in          = 32'h4700_0000;
        @(posedge clk); #1;
        param_ena  = 1'b0;
        pxl_ena_in = 1'b0;
    endtask

    task automatic send_frame(input int win, input int wout, input int h, input int nmax, input int max_gap);
        int n;
        int k;
        bit trig;
        n = 0;
        k = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < win; c++) begin
                if (n >= nmax) return;
                repeat ($urandom_range(0, max_gap)) idle_cycle();
                trig = (r % 2 == 1) && (c % 2 == 1) && (c < (wout & ~1)) && (r < (h & ~1));
                @(posedge clk); #1;
                pxl_ena_in = 1'b1;
                pxl_in     = vin[r * win + c];
                if (trig) begin
                    exp_val.push_back(vexp[k]);
                    exp_cyc.push_back(cyc + 2);
                    k++;
                end
                if (r == h - 1 && c == win - 1) fd_cyc.push_back(cyc + 1);
                n++;
            end
        end
    endtask

    task automatic drain(input string tag);
        repeat (6) idle_cycle();
        check_eq({tag, "_left"}, 32'(exp_val.size()), 32'h0);
        check_eq({tag, "_done_left"}, 32'(fd_cyc.size()), 32'h0);
        exp_val.delete();
        exp_cyc.delete();
        fd_cyc.delete();
    endtask

    task automatic set_ramp(input int sign);
        for (int i = 0; i < 16; i++) vin[i] = fp(sign * (i + 1));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ena_out", {31'b0, pxl_ena_out}, 32'h0);
        check_eq("rst_out", pxl_out, 32'h0);
        check_eq("rst_done", {31'b0, frame_done}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_out", pxl_out, 32'h0);

        // Zero params after reset: samples ignored
        set_ramp(1);
        send_frame(4, 4, 4, 16, 0);
        exp_val.delete();
        exp_cyc.delete();
        fd_cyc.delete();
        load(0, 0, 4, 1'b0);
        set_ramp(1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            pxl_ena_in = 1'b1;
            pxl_in     = vin[i];
        end
        drain("zero_params");

        // 1: positive ramp
        load(4, 4, 4, 1'b0);
        set_ramp(1);
        vexp = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
        send_frame(4, 4, 4, 16, 0);
        drain("t1");

        // 2: negative ramp, without then with ReLU
        set_ramp(-1);
        vexp = '{32'hBF80_0000, 32'hC040_0000, 32'hC110_0000, 32'hC130_0000};
        send_frame(4, 4, 4, 16, 0);
        drain("t2_neg");
        load(4, 4, 4, 1'b1);
        vexp = '{32'h0, 32'h0, 32'h0, 32'h0};
        send_frame(4, 4, 4, 16, 0);
        drain("t2_relu");

        // 3: cropped border columns and trailing odd row
        load(6, 5, 3, 1'b0);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 6; c++) vin[r * 6 + c] = fp(c + 10 * r);
        vexp = '{32'h4130_0000, 32'h4150_0000, 32'h0, 32'h0};
        send_frame(6, 5, 3, 18, 0);
        drain("t3");

        // 4: two gapped frames back-to-back
        load(4, 4, 4, 1'b0);
        set_ramp(1);
        vexp = '{32'h40C0_0000, 32'h4100_0000, 32'h4160_0000, 32'h4180_0000};
        send_frame(4, 4, 4, 16, 2);
        send_frame(4, 4, 4, 16, 2);
        drain("t4");

        // 5a: reset after 9 samples; the sample-7 result is still in flight
        load(4, 4, 4, 1'b0);
        send_frame(4, 4, 4, 9, 0);
        void'(exp_val.pop_back());
        void'(exp_cyc.pop_back());
        @(posedge clk); #1;
        pxl_ena_in = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        check_eq("t5_rst_ena", {31'b0, pxl_ena_out}, 32'h0);
        check_eq("t5_rst_out", pxl_out, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        load(4, 4, 4, 1'b0);
        send_frame(4, 4, 4, 16, 0);
        drain("t5_rst");

        // 5b: param_ena after 9 samples
        send_frame(4, 4, 4, 9, 0);
        load(4, 4, 4, 1'b0);
        send_frame(4, 4, 4, 16, 0);
        drain("t5_pe");

        // 5c: param_ena while the sample-7 result is in stage 1
        send_frame(4, 4, 4, 8, 0);
        void'(exp_val.pop_back());
        void'(exp_cyc.pop_back());
        load(4, 4, 4, 1'b0);
        repeat (3) idle_cycle();
        check_eq("t5_hold_out", pxl_out, 32'h40C0_0000);
        drain("t5_pe_inflight");

        // 6: signed zero and tie
        load(2, 2, 2, 1'b0);
        vin[0] = 32'h0000_0000; vin[1] = 32'h8000_0000;
        vin[2] = 32'h8000_0000; vin[3] = 32'h8000_0000;
        vexp = '{32'h0000_0000, 32'h0, 32'h0, 32'h0};
        send_frame(2, 2, 2, 4, 0);
        vin[0] = fp(2); vin[1] = fp(2); vin[2] = fp(-3); vin[3] = fp(2);
        vexp = '{32'h4000_0000, 32'h0, 32'h0, 32'h0};
        send_frame(2, 2, 2, 4, 0);
        drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
